// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: sizes, S-boxes, round constants, GF(2^8)
// helpers and the decryptor FSM encoding.
package aes_pkg;

  localparam int NR = 10;
  localparam int KW = 128;

  typedef enum logic [2:0] {
    DEC_IDLE  = 3'd0,
    DEC_KEXP  = 3'd1,
    DEC_INIT  = 3'd2,
    DEC_ROUND = 3'd3,
    DEC_FINAL = 3'd4
  } dec_state_e;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Round constant for key-schedule round 1..10 (MSB byte of Rcon word).
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a small constant (up to 15), enough for InvMixColumns.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse-cipher round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when last=1).
// Byte i of a block sits at bits [127-8i -: 8]; row r, column c is byte r+4c.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [KW-1:0] state_in,
  input  logic [KW-1:0] round_key,
  input  logic          last,
  output logic [KW-1:0] state_out
);

  logic [7:0] b_in [16];
  logic [7:0] sb   [16];
  logic [7:0] ark  [16];
  logic [7:0] mc   [16];

  // Full round datapath, byte-wise.
  always_comb begin
    state_out = '0;
    for (int i = 0; i < 16; i++) b_in[i] = state_in[127-8*i -: 8];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sb[r+4*c] = INV_SBOX[b_in[r + 4*((c + 4 - r) % 4)]];
      end
    end
    for (int i = 0; i < 16; i++) ark[i] = sb[i] ^ round_key[127-8*i -: 8];
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = gmul(ark[4*c], 4'd14) ^ gmul(ark[4*c+1], 4'd11) ^ gmul(ark[4*c+2], 4'd13) ^ gmul(ark[4*c+3], 4'd9);
      mc[4*c+1] = gmul(ark[4*c], 4'd9)  ^ gmul(ark[4*c+1], 4'd14) ^ gmul(ark[4*c+2], 4'd11) ^ gmul(ark[4*c+3], 4'd13);
      mc[4*c+2] = gmul(ark[4*c], 4'd13) ^ gmul(ark[4*c+1], 4'd9)  ^ gmul(ark[4*c+2], 4'd14) ^ gmul(ark[4*c+3], 4'd11);
      mc[4*c+3] = gmul(ark[4*c], 4'd11) ^ gmul(ark[4*c+1], 4'd13) ^ gmul(ark[4*c+2], 4'd9)  ^ gmul(ark[4*c+3], 4'd14);
    end
    for (int i = 0; i < 16; i++) state_out[127-8*i -: 8] = last ? ark[i] : mc[i];
  end

endmodule

// File: rtl/aes_key_expansion.sv
// AES-128 key schedule: after a start pulse, streams round keys 0..10,
// one per clock, each tagged with its round number and a valid strobe.
module aes_key_expansion
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [KW-1:0] key,
  output logic [KW-1:0] round_key,
  output logic [3:0]    round,
  output logic          valid
);

  logic [KW-1:0] cur_key;
  logic [KW-1:0] next_key;
  logic [3:0]    rnd;
  logic          active;

  // Derive the next round key from the current one.
  always_comb begin
    logic [31:0] w0, w1, w2, w3, rot, sub, temp, n0, n1, n2, n3;
    w0   = cur_key[127:96];
    w1   = cur_key[95:64];
    w2   = cur_key[63:32];
    w3   = cur_key[31:0];
    rot  = {w3[23:0], w3[31:24]};
    sub  = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
    temp = sub ^ {rcon(rnd + 4'd1), 24'h000000};
    n0   = w0 ^ temp;
    n1   = w1 ^ n0;
    n2   = w2 ^ n1;
    n3   = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  // Load the master key on start, then step through the schedule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_key <= '0;
      rnd     <= '0;
      active  <= 1'b0;
    end else if (start) begin
      cur_key <= key;
      rnd     <= '0;
      active  <= 1'b1;
    end else if (active) begin
      if (rnd == 4'(NR)) begin
        active <= 1'b0;
      end else begin
        cur_key <= next_key;
        rnd     <= rnd + 4'd1;
      end
    end
  end

  assign round_key = cur_key;
  assign round     = rnd;
  assign valid     = active;

endmodule

// File: rtl/aes_decryptor_top.sv
// AES-128 decryptor: expands the key, buffers all 11 round keys, then runs
// the inverse cipher one round per clock using keys 10 down to 0.
// Optional macro AES_DEC_KEY_CACHE_EN adds reuse_key, letting a start skip
// key expansion when the buffer already holds a complete schedule.
module aes_decryptor_top
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
`ifdef AES_DEC_KEY_CACHE_EN
  input  logic          reuse_key,
`endif
  input  logic [KW-1:0] key,
  input  logic [KW-1:0] ciphertext,
  output logic [KW-1:0] plaintext,
  output logic          valid,
  output logic          busy
);

  localparam logic [2:0] S_IDLE  = DEC_IDLE;
  localparam logic [2:0] S_KEXP  = DEC_KEXP;
  localparam logic [2:0] S_INIT  = DEC_INIT;
  localparam logic [2:0] S_ROUND = DEC_ROUND;
  localparam logic [2:0] S_FINAL = DEC_FINAL;

  logic [2:0]    fsm;
  logic [3:0]    cnt;
  logic [KW-1:0] ct_reg;
  logic [KW-1:0] st;
  logic [KW-1:0] rk [0:NR];

  logic          ke_start;
  logic [KW-1:0] ke_round_key;
  logic [3:0]    ke_round;
  logic          ke_valid;
  logic          accept;
  logic          use_cache;
  logic [KW-1:0] inv_out;

`ifdef AES_DEC_KEY_CACHE_EN
  logic cache_valid;
  assign use_cache = reuse_key && cache_valid;
`else
  assign use_cache = 1'b0;
`endif

  // busy stays high through the valid cycle, so a start there is refused.
  assign accept   = (fsm == S_IDLE) && start && !busy;
  assign ke_start = accept && !use_cache;

  aes_key_expansion u_kexp (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (ke_start),
    .key       (key),
    .round_key (ke_round_key),
    .round     (ke_round),
    .valid     (ke_valid)
  );

  aes_inv_round u_round (
    .state_in  (st),
    .round_key (rk[cnt]),
    .last      (fsm == S_FINAL),
    .state_out (inv_out)
  );

  // Round-key buffer; no reset needed since it is always refilled before use.
  always_ff @(posedge clk) begin
    if (fsm == S_KEXP && ke_valid) rk[ke_round] <= ke_round_key;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= S_IDLE;
      cnt       <= '0;
      ct_reg    <= '0;
      st        <= '0;
      plaintext <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_valid <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      if (valid) busy <= 1'b0;
      case (fsm)
        S_IDLE: begin
          if (accept) begin
            ct_reg <= ciphertext;
            busy   <= 1'b1;
            fsm    <= use_cache ? S_INIT : S_KEXP;
          end
        end
        S_KEXP: begin
          if (ke_valid && ke_round == 4'(NR)) begin
            fsm <= S_INIT;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_valid <= 1'b1;
`endif
          end
        end
        S_INIT: begin
          st  <= ct_reg ^ rk[NR];
          cnt <= 4'(NR - 1);
          fsm <= S_ROUND;
        end
        S_ROUND: begin
          st  <= inv_out;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) fsm <= S_FINAL;
        end
        S_FINAL: begin
          plaintext <= inv_out;
          valid     <= 1'b1;
          fsm       <= S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule
